// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit words into a byte-wide instruction memory,
// big-endian, one byte per cycle, while the core is held in reset.
// Ports: clk, rst_n, start, base_addr, in_valid/in_ready/in_word/in_last
//   (word stream), mem_we/mem_addr/mem_wdata (byte write port),
//   busy, done, overflow, words_loaded (status).
// Optional: define IMEM_LOADER_CHECKSUM_EN to add checksum[31:0].
module imem_loader #(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] words_loaded
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        nidx;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       cks_q, cks_d;
  logic [ADDR_W:0]   ptr_end;
  logic              fits;
  logic              unused_base;

  assign unused_base = ^base_addr[1:0];

  // One extra bit so a pointer near the top of the
  // address space cannot wrap and look like it fits.
  assign ptr_end = {1'b0, ptr_q} + (ADDR_W+1)'(4);
  assign fits    = ptr_end <= (ADDR_W+1)'(MEM_BYTES);
  assign nidx    = idx_q + 2'd1;

  function automatic logic [7:0] pick(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    case (i)
      2'd0:    pick = w[31:24];
      2'd1:    pick = w[23:16];
      2'd2:    pick = w[15:8];
      default: pick = w[7:0];
    endcase
  endfunction

  // Byte-port outputs are registered, so they lead the
  // state by one edge: while in WRITE idx k the port
  // shows byte k, and the next byte is prepared here.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    last_d  = last_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    cks_d   = cks_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT;
          ptr_d   = {base_addr[ADDR_W-1:2], 2'b00};
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          cks_d   = '0;
        end
      end
      S_WAIT: begin
        if (!fits) begin
          state_d = S_DONE;
          ovf_d   = 1'b1;
          done_d  = 1'b1;
        end else if (in_valid) begin
          state_d = S_WRITE;
          idx_d   = 2'd0;
          word_d  = in_word;
          last_d  = in_last;
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_word[31:24];
        end
      end
      S_WRITE: begin
        if (idx_q != 2'd3) begin
          idx_d   = nidx;
          we_d    = 1'b1;
          addr_d  = ptr_q + ADDR_W'(nidx);
          wdata_d = pick(word_q, nidx);
        end else begin
          ptr_d = ptr_q + ADDR_W'(4);
          cnt_d = cnt_q + ADDR_W'(1);
          cks_d = cks_q + word_q;
          if (last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      ptr_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      cks_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      cks_q   <= cks_d;
    end
  end

  assign in_ready     = (state_q == S_WAIT) & fits;
  assign busy         = (state_q == S_WAIT) | (state_q == S_WRITE);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign words_loaded = cnt_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum = cks_q;
`else
  logic [31:0] unused_cks;
  assign unused_cks = cks_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a byte
// memory model fed by the write port and immediate-assert checks.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [31:0] words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int nwr = 0;
  logic [7:0] mem [256] = '{default: 8'h00};

  imem_loader #(.MEM_BYTES(64), .ADDR_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_word(in_word),
    .in_last(in_last),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .words_loaded(words_loaded)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      nwr <= nwr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd32(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      nxt();
      n++;
    end
    chk(tag, in_ready, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 30) begin
      nxt();
      n++;
    end
    chk(tag, done, 1);
  endtask

  task automatic pulse_start(input logic [31:0] b);
    start = 1'b1;
    base_addr = b;
    nxt();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic l,
                      input string tag);
    in_word = w;
    in_last = l;
    in_valid = 1'b1;
    wait_ready(tag);
    nxt();
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".mem_we"}, mem_we, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".overflow"}, overflow, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".words"}, words_loaded, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, ".checksum"}, checksum, 0);
`endif
  endtask

  initial begin
    int c0, c1, c2, w0;
    logic [31:0] sw [3];
    sw[0] = 32'h0123_4567;
    sw[1] = 32'h89AB_CDEF;
    sw[2] = 32'hCAFE_F00D;

    // reset state
    nxt();
    nxt();
    chk_idle("rst");
    rst_n = 1'b1;
    nxt();
    chk_idle("rst_rel");

    // T2 single word at 0x10
    pulse_start(32'h10);
    chk("t2.busy", busy, 1);
    chk("t2.ready", in_ready, 1);
    in_word = 32'h8C22_0004;
    in_last = 1'b1;
    in_valid = 1'b1;
    nxt();
    in_valid = 1'b0;
    chk("t2.we0", mem_we, 1);
    chk("t2.a0", mem_addr, 32'h10);
    chk("t2.d0", mem_wdata, 8'h8C);
    chk("t2.rdy_w", in_ready, 0);
    nxt();
    chk("t2.we1", mem_we, 1);
    chk("t2.a1", mem_addr, 32'h11);
    chk("t2.d1", mem_wdata, 8'h22);
    nxt();
    chk("t2.a2", mem_addr, 32'h12);
    chk("t2.d2", mem_wdata, 8'h00);
    nxt();
    chk("t2.a3", mem_addr, 32'h13);
    chk("t2.d3", mem_wdata, 8'h04);
    nxt();
    chk("t2.we_off", mem_we, 0);
    chk("t2.done", done, 1);
    chk("t2.busy_off", busy, 0);
    chk("t2.words", words_loaded, 1);
    chk("t2.mem", rd32(32'h10), 32'h8C22_0004);

    // T3 three-word stream from unaligned base 0x03
    w0 = nwr;
    pulse_start(32'h03);
    chk("t3.done_clr", done, 0);
    chk("t3.words_clr", words_loaded, 0);
    in_valid = 1'b1;
    in_word = sw[0];
    in_last = 1'b0;
    wait_ready("t3.rdy0");
    c0 = cyc;
    nxt();
    in_word = sw[1];
    wait_ready("t3.rdy1");
    c1 = cyc;
    nxt();
    in_word = sw[2];
    in_last = 1'b1;
    wait_ready("t3.rdy2");
    c2 = cyc;
    nxt();
    in_valid = 1'b0;
    wait_done("t3.done");
    chk("t3.gap01", c1 - c0, 5);
    chk("t3.gap12", c2 - c1, 5);
    chk("t3.words", words_loaded, 3);
    chk("t3.nwr", nwr - w0, 12);
    chk("t3.m0", rd32(0), sw[0]);
    chk("t3.m4", rd32(4), sw[1]);
    chk("t3.m8", rd32(8), sw[2]);

    // T4 overflow at the top of a 64-byte memory
    w0 = nwr;
    pulse_start(32'h3C);
    send(32'h1122_3344, 1'b0, "t4.rdy0");
    in_word = 32'h5566_7788;
    in_last = 1'b1;
    in_valid = 1'b1;
    c0 = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready === 1'b1) c0++;
      nxt();
    end
    in_valid = 1'b0;
    chk("t4.no_ready", c0, 0);
    chk("t4.ovf", overflow, 1);
    chk("t4.done", done, 1);
    chk("t4.words", words_loaded, 1);
    chk("t4.nwr", nwr - w0, 4);
    chk("t4.m3c", rd32(32'h3C), 32'h1122_3344);
    chk("t4.m40", mem[64], 8'h00);

    // T5 backpressure and start while busy
    w0 = nwr;
    pulse_start(32'h20);
    chk("t5.ovf_clr", overflow, 0);
    in_word = 32'hA1A2_A3A4;
    in_last = 1'b0;
    nxt();
    nxt();
    chk("t5.hold_busy", busy, 1);
    chk("t5.hold_nwr", nwr - w0, 0);
    in_valid = 1'b1;
    wait_ready("t5.rdyA");
    nxt();
    in_valid = 1'b0;
    chk("t5.aA0", mem_addr, 32'h20);
    nxt();
    start = 1'b1;
    base_addr = 32'h0;
    in_valid = 1'b1;
    in_word = 32'hBAD0_BAD0;
    nxt();
    start = 1'b0;
    in_valid = 1'b0;
    in_word = 32'hB1B2_B3B4;
    in_last = 1'b1;
    chk("t5.aA2", mem_addr, 32'h22);
    chk("t5.dA2", mem_wdata, 8'hA3);
    send(32'hB1B2_B3B4, 1'b1, "t5.rdyB");
    wait_done("t5.done");
    chk("t5.words", words_loaded, 2);
    chk("t5.nwr", nwr - w0, 8);
    chk("t5.m20", rd32(32'h20), 32'hA1A2_A3A4);
    chk("t5.m24", rd32(32'h24), 32'hB1B2_B3B4);
    chk("t5.m0_kept", rd32(0), sw[0]);
    chk("t5.ovf", overflow, 0);

    // T1 reset in the middle of a word
    pulse_start(32'h30);
    in_word = 32'hDEAD_BEEF;
    in_last = 1'b1;
    in_valid = 1'b1;
    nxt();
    in_valid = 1'b0;
    nxt();
    chk("t1.we_pre", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("t1.we_async", mem_we, 0);
    w0 = nwr;
    nxt();
    nxt();
    chk("t1.nwr", nwr - w0, 0);
    rst_n = 1'b1;
    nxt();
    chk_idle("t1");
    nxt();
    chk("t1.nwr2", nwr - w0, 0);
    chk("t1.m30", mem[48], 8'hDE);
    chk("t1.m31", mem[49], 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // T6 checksum wraps modulo 2^32
    pulse_start(32'h0);
    send(32'hFFFF_FFFF, 1'b0, "t6.rdy0");
    send(32'h0000_0002, 1'b1, "t6.rdy1");
    wait_done("t6.done");
    chk("t6.cks", checksum, 32'h0000_0001);
    chk("t6.words", words_loaded, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
